// File: rtl/dpwm_dither_dt_if.sv
// Command/gate bundle between the PID compensator side and the DPWM core.
// The master drives the duty/deadtime command; the slave returns the gate pair.
interface dpwm_dither_dt_if #(
    parameter int CNT_W  = 6,
    parameter int DITH_W = 3,
    parameter int DT_W   = 4
);
    logic                    enable;
    logic [CNT_W+DITH_W-1:0] duty_in;
    logic [DT_W-1:0]         dt_rise;
    logic [DT_W-1:0]         dt_fall;
    logic                    duty_high;
    logic                    duty_low;
    logic                    period_start;

    modport master (
        output enable, duty_in, dt_rise, dt_fall,
        input  duty_high, duty_low, period_start
    );

    modport slave (
        input  enable, duty_in, dt_rise, dt_fall,
        output duty_high, duty_low, period_start
    );
endinterface

// File: rtl/dpwm_dither_dt.sv
// Hybrid DPWM: counter gives coarse duty, temporal dither over 2^DITH_W periods
// gives fine LSBs; complementary gate pair with programmable rise/fall deadtime.
module dpwm_dither_dt #(
    parameter int CNT_W  = 6,
    parameter int DITH_W = 3,
    parameter int DT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dpwm_dither_dt_if.slave       bus
);
    logic [CNT_W-1:0]  r_cnt;
    logic [DITH_W-1:0] r_phase;
    logic [CNT_W:0]    r_effQ;
    logic [DT_W-1:0]   r_dtRiseQ;
    logic [DT_W-1:0]   r_dtFallQ;
    logic [DT_W-1:0]   r_hiRun;
    logic [DT_W-1:0]   r_loRun;
    logic              r_dutyHigh;
    logic              r_dutyLow;
    logic              r_periodStart;

    logic              w_run;
    logic              w_raw;
    logic              w_wrap;
    logic [DITH_W-1:0] w_phaseNext;
    logic [CNT_W-1:0]  w_coarse;
    logic [DITH_W-1:0] w_fine;
    logic [CNT_W:0]    w_effNext;
    logic [DT_W-1:0]   w_hiRunNext;
    logic [DT_W-1:0]   w_loRunNext;

    assign w_run       = bus.enable & ~rst;
    assign w_raw       = w_run & ({1'b0, r_cnt} < r_effQ);
    assign w_wrap      = (r_cnt == {CNT_W{1'b1}});
    assign w_phaseNext = r_phase + 1'b1;
    assign w_coarse    = bus.duty_in[CNT_W+DITH_W-1 -: CNT_W];
    assign w_fine      = bus.duty_in[DITH_W-1:0];
    assign w_effNext   = {1'b0, w_coarse} + {{CNT_W{1'b0}}, (w_phaseNext < w_fine)};

    // Run lengths saturate at the largest programmable deadtime, which is all the windows need.
    assign w_hiRunNext = (r_hiRun == {DT_W{1'b1}}) ? r_hiRun : r_hiRun + 1'b1;
    assign w_loRunNext = (r_loRun == {DT_W{1'b1}}) ? r_loRun : r_loRun + 1'b1;

    // Disable behaves exactly like reset so the next enabled edge starts a fresh aligned period.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_cnt         <= {CNT_W{1'b1}};
            r_phase       <= {DITH_W{1'b1}};
            r_effQ        <= '0;
            r_dtRiseQ     <= '0;
            r_dtFallQ     <= '0;
            r_hiRun       <= '0;
            r_loRun       <= '0;
            r_dutyHigh    <= 1'b0;
            r_dutyLow     <= 1'b0;
            r_periodStart <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 1'b1;
            r_periodStart <= w_wrap;
            if (w_wrap) begin
                r_phase   <= w_phaseNext;
                r_effQ    <= w_effNext;
                r_dtRiseQ <= bus.dt_rise;
                r_dtFallQ <= bus.dt_fall;
            end
            // A gate asserts once the raw level has held for deadtime+1 cycles.
            r_dutyHigh <= w_raw & (r_hiRun >= r_dtRiseQ);
            r_dutyLow  <= ~w_raw & (r_loRun >= r_dtFallQ);
            r_hiRun    <= w_raw ? w_hiRunNext : '0;
            r_loRun    <= w_raw ? '0 : w_loRunNext;
        end
    end

    assign bus.duty_high    = r_dutyHigh;
    assign bus.duty_low     = r_dutyLow;
    assign bus.period_start = r_periodStart;
endmodule

// File: tb/tb_dpwm_dither_dt.sv
// Self-checking bench for dpwm_dither_dt: directed test-plan steps followed by
// randomized commands, compared every cycle against a window-based reference model.
module tb_dpwm_dither_dt;
    localparam int CNT_W  = 6;
    localparam int DITH_W = 3;
    localparam int DT_W   = 4;
    localparam int PER    = 1 << CNT_W;
    localparam int NPH    = 1 << DITH_W;

    logic clk;
    logic rst;
    int   testCount;
    int   failCount;
    int   highCycles;

    // Reference model state
    int   mCnt;
    int   mPhase;
    int   mEff;
    int   mDtr;
    int   mDtf;
    bit   hist[$];

    dpwm_dither_dt_if #(.CNT_W(CNT_W), .DITH_W(DITH_W), .DT_W(DT_W)) bus ();

    dpwm_dither_dt #(.CNT_W(CNT_W), .DITH_W(DITH_W), .DT_W(DT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit lastAll(bit v, int n);
        if (hist.size() < n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (hist[hist.size() - 1 - i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input bit en, input int duty, input int dtr, input int dtf, input bit rs);
        bus.enable  = en;
        bus.duty_in = duty[CNT_W+DITH_W-1:0];
        bus.dt_rise = dtr[DT_W-1:0];
        bus.dt_fall = dtf[DT_W-1:0];
        rst         = rs;
    endtask

    // One clock: advance the model across the edge, then compare the registered outputs.
    task automatic checkOutput();
        bit run, r, expHigh, expLow, expPs;
        run = bus.enable && !rst;
        r   = run && (mCnt < mEff);
        expHigh = 1'b0;
        expLow  = 1'b0;
        expPs   = 1'b0;
        if (!run) begin
            hist.delete();
            mCnt = PER - 1; mPhase = NPH - 1; mEff = 0; mDtr = 0; mDtf = 0;
        end else begin
            hist.push_back(r);
            if (hist.size() > 32) void'(hist.pop_front());
            expHigh = lastAll(1'b1, mDtr + 1);
            expLow  = lastAll(1'b0, mDtf + 1);
            mCnt = (mCnt + 1) % PER;
            expPs = (mCnt == 0);
            if (mCnt == 0) begin
                mPhase = (mPhase + 1) % NPH;
                mEff   = int'(bus.duty_in) / NPH + ((mPhase < int'(bus.duty_in) % NPH) ? 1 : 0);
                mDtr   = int'(bus.dt_rise);
                mDtf   = int'(bus.dt_fall);
            end
        end
        @(posedge clk);
        #1;
        if (bus.duty_high === 1'b1) highCycles++;
        testCount++;
        assert (bus.duty_high === expHigh) else begin
            failCount++;
            $error("FAIL duty_high t=%0t observed=%b expected=%b", $time, bus.duty_high, expHigh);
        end
        testCount++;
        assert (bus.duty_low === expLow) else begin
            failCount++;
            $error("FAIL duty_low t=%0t observed=%b expected=%b", $time, bus.duty_low, expLow);
        end
        testCount++;
        assert (bus.period_start === expPs) else begin
            failCount++;
            $error("FAIL period_start t=%0t observed=%b expected=%b", $time, bus.period_start, expPs);
        end
        testCount++;
        assert ((bus.duty_high & bus.duty_low) === 1'b0) else begin
            failCount++;
            $error("FAIL overlap t=%0t observed=%b expected=0", $time, bus.duty_high & bus.duty_low);
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) checkOutput();
    endtask

    initial begin
        int duty, dtr, dtf;
        testCount  = 0;
        failCount  = 0;
        highCycles = 0;
        mCnt = PER - 1; mPhase = NPH - 1; mEff = 0; mDtr = 0; mDtf = 0;

        // Reset state
        applyStimulus(1'b1, 160, 0, 0, 1'b1);
        runCycles(3);

        // Constant 160, no deadtime
        applyStimulus(1'b1, 160, 0, 0, 1'b0);
        runCycles(3 * PER);

        // Dither sum over one full dither cycle from reset
        applyStimulus(1'b1, 163, 0, 0, 1'b1);
        runCycles(1);
        applyStimulus(1'b1, 163, 0, 0, 1'b0);
        highCycles = 0;
        runCycles(NPH * PER + 1);
        testCount++;
        assert (highCycles === 163) else begin
            failCount++;
            $error("FAIL dither_sum observed=%0d expected=163", highCycles);
        end

        // Asymmetric deadtime
        applyStimulus(1'b1, 160, 3, 2, 1'b0);
        runCycles(3 * PER);

        // Full scale then zero
        applyStimulus(1'b1, 511, 0, 0, 1'b0);
        runCycles(9 * PER);
        applyStimulus(1'b1, 0, 0, 0, 1'b0);
        runCycles(2 * PER);

        // Pulse shorter than deadtime is swallowed
        applyStimulus(1'b1, 8, 15, 2, 1'b0);
        runCycles(3 * PER);

        // Reset and disable mid-period
        applyStimulus(1'b1, 160, 0, 0, 1'b0);
        runCycles(PER + 30);
        applyStimulus(1'b1, 160, 0, 0, 1'b1);
        runCycles(1);
        applyStimulus(1'b1, 160, 0, 0, 1'b0);
        runCycles(PER + 30);
        applyStimulus(1'b0, 160, 0, 0, 1'b0);
        runCycles(2);
        applyStimulus(1'b1, 160, 0, 0, 1'b0);
        runCycles(PER);

        // Randomized commands, occasional disable/reset
        for (int k = 0; k < 60; k++) begin
            duty = int'($urandom_range(0, (1 << (CNT_W + DITH_W)) - 1));
            dtr  = int'($urandom_range(0, (1 << DT_W) - 1));
            dtf  = int'($urandom_range(0, (1 << DT_W) - 1));
            applyStimulus(1'b1, duty, dtr, dtf, 1'b0);
            runCycles(int'($urandom_range(20, 3 * PER)));
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b0, duty, dtr, dtf, 1'b0);
                runCycles(int'($urandom_range(1, 4)));
            end else if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, duty, dtr, dtf, 1'b1);
                runCycles(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
